// File: rtl/servo_pkg.sv
// Shared servo definitions: pulse limits, reset defaults and the shaper state encoding.
package servo_pkg;

    localparam int unsigned DEF_DUTY_W     = 28;
    localparam int unsigned DEF_MIN_PULSE  = 50000;
    localparam int unsigned DEF_MAX_PULSE  = 100000;
    localparam int unsigned DEF_MIN_PERIOD = 200000;
    localparam int unsigned DEF_RST_DUTY   = 75000;
    localparam int unsigned DEF_RST_PERIOD = 1000000;
    localparam int unsigned STEP_W         = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } servo_state_t;

endpackage

// File: rtl/servo_cmd_shaper_if.sv
// Command handshake between a position source and the servo command shaper.
interface servo_cmd_shaper_if #(
    parameter int unsigned DUTY_W = servo_pkg::DEF_DUTY_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_pos;
    logic [DUTY_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_pos,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pos,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/servo_slew_step.sv
// Combinational command clamping and one-period slew step toward the target.
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
    parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic [DUTY_W-1:0] duty,
    input  logic [DUTY_W-1:0] target,
    input  logic [STEP_W-1:0] step_max,
    input  logic [DUTY_W-1:0] cmd_pos,
    input  logic [DUTY_W-1:0] cmd_period,
    output logic [DUTY_W-1:0] next_duty_c,
    output logic [DUTY_W-1:0] pos_clamped_c,
    output logic [DUTY_W-1:0] period_clamped_c
);

    localparam int unsigned DW = DUTY_W + 1;

    logic signed [DW-1:0] diff_c;
    logic signed [DW-1:0] mag_c;
    logic signed [DW-1:0] step_c;
    logic signed [DW-1:0] sum_c;

    // Clamp incoming command fields to the permitted pulse and period range.
    always_comb begin
        pos_clamped_c    = cmd_pos;
        period_clamped_c = cmd_period;
        if (cmd_pos < DUTY_W'(MIN_PULSE)) begin
            pos_clamped_c = DUTY_W'(MIN_PULSE);
        end else if (cmd_pos > DUTY_W'(MAX_PULSE)) begin
            pos_clamped_c = DUTY_W'(MAX_PULSE);
        end
        if (cmd_period < DUTY_W'(MIN_PERIOD)) begin
            period_clamped_c = DUTY_W'(MIN_PERIOD);
        end
    end

    // Move duty toward target by at most step_max; zero step means jump straight there.
    always_comb begin
        diff_c      = $signed({1'b0, target}) - $signed({1'b0, duty});
        mag_c       = diff_c[DW-1] ? -diff_c : diff_c;
        step_c      = $signed({{(DW-STEP_W){1'b0}}, step_max});
        sum_c       = $signed({1'b0, duty});
        next_duty_c = target;
        if ((step_max != '0) && (mag_c > step_c)) begin
            sum_c       = diff_c[DW-1] ? ($signed({1'b0, duty}) - step_c)
                                       : ($signed({1'b0, duty}) + step_c);
            next_duty_c = sum_c[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/servo_cmd_shaper.sv
// Servo command shaper: accepts position/period commands and slews the PWM duty
// toward the target one bounded step per PWM period.
module servo_cmd_shaper
    import servo_pkg::*;
#(
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
    parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int unsigned RST_DUTY   = DEF_RST_DUTY,
    parameter int unsigned RST_PERIOD = DEF_RST_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    servo_cmd_shaper_if.slave  cmd,
    input  logic [STEP_W-1:0]  step_max,
    input  logic               period_end,
    output logic [DUTY_W-1:0]  duty,
    output logic [DUTY_W-1:0]  period,
    output logic               at_target
);

    servo_state_t      state;
    logic [DUTY_W-1:0] duty_int;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] shadow_period;

    logic              accept_c;
    logic [DUTY_W-1:0] next_duty_c;
    logic [DUTY_W-1:0] pos_clamped_c;
    logic [DUTY_W-1:0] period_clamped_c;
    logic [DUTY_W-1:0] step_duty_c;
    logic [DUTY_W-1:0] target_nxt_c;
    logic [DUTY_W-1:0] duty_nxt_c;

    servo_slew_step #(
        .DUTY_W     (DUTY_W),
        .MIN_PULSE  (MIN_PULSE),
        .MAX_PULSE  (MAX_PULSE),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_step (
        .duty             (duty_int),
        .target           (target),
        .step_max         (step_max),
        .cmd_pos          (cmd.cmd_pos),
        .cmd_period       (cmd.cmd_period),
        .next_duty_c      (next_duty_c),
        .pos_clamped_c    (pos_clamped_c),
        .period_clamped_c (period_clamped_c)
    );

    // Acceptance and the values duty/target will hold after this edge.
    always_comb begin
        accept_c     = cmd.cmd_valid && cmd.cmd_ready;
        step_duty_c  = (state == ST_SLEW) ? next_duty_c : duty_int;
        target_nxt_c = accept_c ? pos_clamped_c : target;
        duty_nxt_c   = period_end ? step_duty_c : duty_int;
    end

    // Command capture, per-period duty/period update and IDLE/SLEW tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            duty_int      <= DUTY_W'(RST_DUTY);
            target        <= DUTY_W'(RST_DUTY);
            shadow_period <= DUTY_W'(RST_PERIOD);
            period        <= DUTY_W'(RST_PERIOD);
            duty          <= DUTY_W'(RST_DUTY);
            cmd.cmd_ready <= 1'b1;
        end else begin
            cmd.cmd_ready <= !accept_c;
            if (accept_c) begin
                target        <= pos_clamped_c;
                shadow_period <= period_clamped_c;
            end
            // The step and period load see the pre-acceptance target and shadow.
            if (period_end) begin
                period   <= shadow_period;
                duty_int <= step_duty_c;
            end
            // Disable forces the output low at once; re-enable waits for a period boundary.
            if (!enable) begin
                duty <= '0;
            end else if (period_end) begin
                duty <= step_duty_c;
            end
            case (state)
                ST_IDLE: if (target_nxt_c != duty_nxt_c) state <= ST_SLEW;
                ST_SLEW: if (target_nxt_c == duty_nxt_c) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // at_target decodes the settled state.
    assign at_target = (state == ST_IDLE);

endmodule

// File: tb/tb_servo_cmd_shaper.sv
// Directed self-checking bench for servo_cmd_shaper.
module tb_servo_cmd_shaper;

    localparam int unsigned DUTY_W = 28;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0]       step_max;
    logic              period_end;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] period;
    logic              at_target;

    int n_tests = 0;
    int n_fail  = 0;

    servo_cmd_shaper_if #(.DUTY_W(DUTY_W)) cmd_if ();

    servo_cmd_shaper dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cmd        (cmd_if.slave),
        .step_max   (step_max),
        .period_end (period_end),
        .duty       (duty),
        .period     (period),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pe();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic send_cmd(input logic [DUTY_W-1:0] pos, input logic [DUTY_W-1:0] per);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 8) begin
            tick();
            n++;
        end
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_cmd_ready_timeout: cmd_ready=%b required 1", cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_pos    = pos;
        cmd_if.cmd_period = per;
        tick();
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if (duty !== 28'd75000 || period !== 28'd1000000 || at_target !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: duty=%0d period=%0d at_target=%b ready=%b required 75000 1000000 1 1",
                     duty, period, at_target, cmd_if.cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_pe();
            n_tests++;
            if (duty !== 28'd75000 || period !== 28'd1000000 || at_target !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle_pe%0d: duty=%0d period=%0d at_target=%b required 75000 1000000 1",
                         i, duty, period, at_target);
            end
        end
    endtask

    task automatic test_slew();
        logic [DUTY_W-1:0] exp_d [3];
        exp_d[0] = 28'd85000; exp_d[1] = 28'd95000; exp_d[2] = 28'd100000;
        step_max = 16'd10000;
        send_cmd(28'd100000, 28'd1000000);
        n_tests++;
        if (cmd_if.cmd_ready !== 1'b0 || at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL slew_after_accept: ready=%b at_target=%b required 0 0", cmd_if.cmd_ready, at_target);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_pe();
            n_tests++;
            if (duty !== exp_d[i]) begin
                n_fail++;
                $display("FAIL slew_step%0d: duty=%0d required %0d", i, duty, exp_d[i]);
            end
        end
        n_tests++;
        if (at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL slew_done: at_target=%b required 1", at_target);
        end
    endtask

    task automatic test_clamp();
        step_max = 16'd0;
        send_cmd(28'd10, 28'd1000);
        pulse_pe();
        n_tests++;
        if (duty !== 28'd50000 || period !== 28'd200000) begin
            n_fail++;
            $display("FAIL clamp_low: duty=%0d period=%0d required 50000 200000", duty, period);
        end
        send_cmd(28'd500000, 28'd1000000);
        pulse_pe();
        n_tests++;
        if (duty !== 28'd100000 || period !== 28'd1000000 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_high: duty=%0d period=%0d at_target=%b required 100000 1000000 1",
                     duty, period, at_target);
        end
    endtask

    task automatic test_same_cycle();
        step_max = 16'd0;
        tick();
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_pos    = 28'd60000;
        cmd_if.cmd_period = 28'd400000;
        period_end        = 1'b1;
        tick();
        cmd_if.cmd_valid  = 1'b0;
        period_end        = 1'b0;
        n_tests++;
        if (duty !== 28'd100000 || period !== 28'd1000000) begin
            n_fail++;
            $display("FAIL same_cycle_edge: duty=%0d period=%0d required 100000 1000000", duty, period);
        end
        tick();
        pulse_pe();
        n_tests++;
        if (duty !== 28'd60000 || period !== 28'd400000) begin
            n_fail++;
            $display("FAIL same_cycle_next_pe: duty=%0d period=%0d required 60000 400000", duty, period);
        end
    endtask

    task automatic test_retarget();
        logic [DUTY_W-1:0] exp_d [3];
        exp_d[0] = 28'd75000; exp_d[1] = 28'd65000; exp_d[2] = 28'd60000;
        step_max = 16'd0;
        send_cmd(28'd75000, 28'd1000000);
        pulse_pe();
        step_max = 16'd10000;
        send_cmd(28'd100000, 28'd1000000);
        pulse_pe();
        n_tests++;
        if (duty !== 28'd85000) begin
            n_fail++;
            $display("FAIL retarget_mid: duty=%0d required 85000", duty);
        end
        send_cmd(28'd60000, 28'd1000000);
        for (int i = 0; i < 3; i++) begin
            pulse_pe();
            n_tests++;
            if (duty !== exp_d[i]) begin
                n_fail++;
                $display("FAIL retarget_step%0d: duty=%0d required %0d", i, duty, exp_d[i]);
            end
        end
        n_tests++;
        if (at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL retarget_done: at_target=%b required 1", at_target);
        end
    endtask

    task automatic test_enable();
        step_max = 16'd10000;
        send_cmd(28'd90000, 28'd1000000);
        enable = 1'b0;
        tick();
        n_tests++;
        if (duty !== 28'd0) begin
            n_fail++;
            $display("FAIL enable_off: duty=%0d required 0", duty);
        end
        pulse_pe();
        pulse_pe();
        n_tests++;
        if (duty !== 28'd0 || at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_off_slew: duty=%0d at_target=%b required 0 0", duty, at_target);
        end
        enable = 1'b1;
        tick();
        n_tests++;
        if (duty !== 28'd0) begin
            n_fail++;
            $display("FAIL enable_wait_pe: duty=%0d required 0", duty);
        end
        pulse_pe();
        n_tests++;
        if (duty !== 28'd90000 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_resume: duty=%0d at_target=%b required 90000 1", duty, at_target);
        end
    endtask

    task automatic test_reset_mid_slew();
        step_max = 16'd10000;
        send_cmd(28'd50000, 28'd400000);
        pulse_pe();
        n_tests++;
        if (duty !== 28'd80000 || at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_slew_pre: duty=%0d at_target=%b required 80000 0", duty, at_target);
        end
        reset             = 1'b1;
        period_end        = 1'b1;
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_pos    = 28'd100000;
        cmd_if.cmd_period = 28'd300000;
        tick();
        reset            = 1'b0;
        period_end       = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        n_tests++;
        if (duty !== 28'd75000 || period !== 28'd1000000 || at_target !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_slew_post: duty=%0d period=%0d at_target=%b ready=%b required 75000 1000000 1 1",
                     duty, period, at_target, cmd_if.cmd_ready);
        end
        pulse_pe();
        n_tests++;
        if (duty !== 28'd75000 || period !== 28'd1000000 || at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_slew_settled: duty=%0d period=%0d at_target=%b required 75000 1000000 1",
                     duty, period, at_target);
        end
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b1;
        step_max          = 16'd0;
        period_end        = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_pos    = '0;
        cmd_if.cmd_period = '0;
        #1;
        test_reset();
        test_slew();
        test_clamp();
        test_same_cycle();
        test_retarget();
        test_enable();
        test_reset_mid_slew();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_cmd_shaper.md
SERVO_CMD_SHAPER -- requirements
Module: servo_cmd_shaper

Interface
REQ-001 Parameter DUTY_W, default 28: width of the duty and period words fed to the PWM counter stage.
REQ-002 Parameter MIN_PULSE, default 50000: lowest permitted duty in clk ticks (1.0 ms at 50 MHz).
REQ-003 Parameter MAX_PULSE, default 100000: highest permitted duty in clk ticks (2.0 ms).
REQ-004 Parameter MIN_PERIOD, default 200000: lowest permitted period in clk ticks (4 ms).
REQ-005 Parameter RST_DUTY, default 75000: duty and target after reset (1.5 ms, centre).
REQ-006 Parameter RST_PERIOD, default 1000000: period after reset (20 ms).
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  1 = drive pulses; 0 = force duty output to 0.
REQ-010 cmd_valid  in  1  a new command is present on cmd_pos and cmd_period.
REQ-011 cmd_ready  out  1  the shaper accepts a command this cycle.
REQ-012 cmd_pos  in  DUTY_W  target pulse width in ticks.
REQ-013 cmd_period  in  DUTY_W  requested PWM period in ticks.
REQ-014 step_max  in  16  maximum duty change per PWM period; 0 means jump directly to the target.
REQ-015 period_end  in  1  one-cycle pulse from the PWM stage marking counter wrap.
REQ-016 duty  out  DUTY_W  registered compare value for the PWM stage.
REQ-017 period  out  DUTY_W  registered period value for the PWM stage.
REQ-018 at_target  out  1  high when the internal duty equals the target.

Function
REQ-019 A command is accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-020 cmd_ready is low only in the cycle after an acceptance, giving at most one command per 2 cycles.
REQ-021 At acceptance, cmd_pos is clamped to [MIN_PULSE, MAX_PULSE] and stored as target.
REQ-022 At acceptance, cmd_period is clamped to >= MIN_PERIOD and stored in a shadow period register.
REQ-023 The FSM has states IDLE (duty == target) and SLEW (duty != target).
REQ-024 IDLE -> SLEW on the first cycle after an acceptance that makes target differ from duty.
REQ-025 In SLEW, each period_end moves duty toward target by min(step_max, |target - duty|); step_max = 0 moves the full distance.
REQ-026 SLEW -> IDLE in the cycle after the step that makes duty equal target.
REQ-027 duty and period change only on a period_end cycle, so a PWM cycle never sees a mid-period update.
REQ-028 On every period_end, period is loaded from the shadow register.
REQ-029 If acceptance and period_end occur in the same cycle, the step uses the old target and the old shadow period; the new values first apply at the next period_end.
REQ-030 A new command accepted during SLEW retargets without resetting duty, and the slew continues from the current duty.
REQ-031 While enable = 0, the duty output is 0; the internal duty, target, state and period updates continue.
REQ-032 When enable rises, the internal duty value drives the output from the next period_end.
REQ-033 Difference arithmetic uses DUTY_W+1 bits signed; duty never leaves [MIN_PULSE, MAX_PULSE].
REQ-034 at_target is a combinational decode of state == IDLE.

Reset
REQ-035 While reset is high on a rising edge: duty = RST_DUTY, target = RST_DUTY, period and shadow period = RST_PERIOD, state = IDLE, cmd_ready = 1.
REQ-036 Reset asserted during SLEW abandons the slew with no partial step.
REQ-037 Reset takes precedence over acceptance and period_end in the same cycle.

Structure
REQ-038 Reset defaults, pulse limits and the state enum live in the shared package servo_pkg, which the PWM stage also uses.
REQ-039 The clamp/step arithmetic is one sub-module, servo_slew_step, which is combinational and computes the next duty from duty, target and step_max.

Verification
REQ-040 Reset, then 3 period_end pulses -> duty = 75000, period = 1000000, at_target = 1 throughout.
REQ-041 cmd_pos = 100000, step_max = 10000 -> duty reads 85000, 95000, 100000 after successive period_end pulses, then at_target = 1.
REQ-042 cmd_pos = 10, then cmd_pos = 500000 -> targets clamp to 50000 and 100000; cmd_period = 1000 -> period becomes 200000 at the next period_end.
REQ-043 Accept a command in the same cycle as period_end -> duty unchanged at that edge; the first step occurs at the next period_end.
REQ-044 Retarget to 60000 midway through a slew toward 100000 (duty = 85000, step_max = 10000) -> duty reads 75000, 65000, 60000.
REQ-045 enable = 0 during a slew -> duty output = 0, and the internal progression continues; assert reset mid-slew -> duty = 75000 on the next cycle.
